pipeline_ctrl: RTL
==================

// Module: pipeline_ctrl
// PURPOSE
//   Pipeline control unit. Drives the stall[5:0] vector consumed by every inter-stage register
//   (bits: 0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB) and the flush/new_pc pair used for exceptions.
//   Per-stage stall requests are merged into one stall vector. Exceptions are sequenced
//   freeze -> flush. The block also keeps a stall-cycle perf counter and a stuck-stall watchdog.
// PARAMETERS
//   STALL_TIMEOUT  1024  consecutive requested-stall cycles before stall_timeout latches
//   CNT_W          32    width of the stall_cycles perf counter
// PORTS
//   clk            in   1      clock; all state updates on posedge
//   rst            in   reset_status_t  synchronous, active-high; RST_ENABLE = in reset
//   stallreq_id    in   1      ID requests a stall (load-use hazard)
//   stallreq_ex    in   1      EX requests a stall (multi-cycle mul/div)
//   stallreq_mem   in   1      MEM requests a stall (data memory wait)
//   excp_valid     in   1      MEM-stage exception detected this cycle
//   excp_pc        in   pc_t   handler address; sampled together with excp_valid
//   stall          out  stall_t  stall vector to PC and all pipeline registers
//   flush          out  1      clear all pipeline registers; PC loads new_pc
//   new_pc         out  pc_t   redirect target; valid while flush=1
//   stall_cycles   out  CNT_W  saturating count of cycles with stall != 0
//   stall_timeout  out  1      sticky watchdog flag
// BEHAVIOUR
//   - Reset (rst==RST_ENABLE at posedge): state=RUN, flush=0, new_pc=0, stall_cycles=0,
//     stall_timeout=0, run counter=0. While rst==RST_ENABLE, stall is forced to STALL_NONE.
//   - stall is combinational from the inputs, with zero latency:
//       state FLUSH            -> STALL_NONE
//       RUN and excp_valid     -> STALL_ALL (6'b111111), which freezes the excepting instruction
//       RUN, else priority     -> mem ? 6'b011111 : ex ? 6'b001111 : id ? 6'b000111 : 6'b000000
//     The highest requesting stage wins. Lower-stage requests are subsumed by it.
//   - The stage just above the stalled prefix (stall[k]=1 and stall[k+1]=0) inserts a bubble.
//     This is the contract every pipeline register relies on.
//   - FSM, states RUN and FLUSH:
//       RUN   & excp_valid -> FLUSH; flush<=1, new_pc<=excp_pc
//       FLUSH              -> RUN; flush<=0 (flush is exactly a 1-cycle pulse)
//     excp_valid or stallreq_* asserted during FLUSH are ignored. Requests are re-evaluated in RUN.
//     Back-to-back exceptions: the second one is seen again in RUN and gets a new freeze/flush.
//   - flush and new_pc are registered. new_pc holds its value after flush drops.
//   - stall_cycles: +1 at each posedge where stall != 0 (freeze cycle included).
//     It saturates at all-ones and does not wrap.
//   - Watchdog run counter:
//       +1 at each posedge in RUN where any stallreq_* = 1
//       cleared otherwise, and cleared in FLUSH
//       run counter reaching STALL_TIMEOUT sets stall_timeout=1; it stays set until reset
//     Counter width is $clog2(STALL_TIMEOUT+1), and it saturates.
//   - Reset asserted mid-FLUSH: FSM returns to RUN and flush=0 at that edge.
// STRUCTURE
//   - project_types holds:
//       typedef logic [5:0] stall_t
//       STALL_NONE, STALL_ID=6'b000111, STALL_EX=6'b001111, STALL_MEM=6'b011111,
//       STALL_ALL=6'b111111
//       enum ctrl_state_t {CTRL_RUN, CTRL_FLUSH}
//   - Sub-module stall_watchdog (parameter STALL_TIMEOUT; ports clk, rst, req_any, clr, timeout)
//     holds the run counter and the sticky flag.
//   - pipeline_ctrl keeps the FSM, the stall mux and the perf counter.
// TESTING
//   1. Hold stallreq_id=1 for 3 cycles -> stall=6'b000111 for those 3 cycles, stall_cycles=3.
//   2. stallreq_id=1 & stallreq_mem=1 in the same cycle -> stall=6'b011111.
//      stallreq_ex alone -> stall=6'b001111.
//   3. excp_valid=1, excp_pc=32'hBFC00380 in cycle N -> stall=6'b111111 in N; flush=1,
//      new_pc=32'hBFC00380, stall=0 in N+1; flush=0 in N+2.
//   4. excp_valid held 2 cycles -> cycle N freezes, N+1 flushes (input ignored),
//      N+2 freezes again, N+3 flushes again.
//   5. STALL_TIMEOUT=8, stallreq_ex held 8 cycles -> stall_timeout=1 after the 8th edge.
//      It stays 1 after the request drops; a 7-cycle request followed by a gap leaves it 0.
//   6. Assert rst during FLUSH -> next cycle flush=0, stall=0, stall_cycles=0, stall_timeout=0.

Source files
------------

// File: rtl/project_types.sv
`default_nettype none
// project_types: shared types and stall-vector constants for the pipeline control slice.
package project_types;

  typedef logic [5:0]  stall_t;
  typedef logic [31:0] pc_t;

  typedef enum logic {
    RST_DISABLE = 1'b0,
    RST_ENABLE  = 1'b1
  } reset_status_t;

  typedef enum logic [0:0] {
    CTRL_RUN   = 1'b0,
    CTRL_FLUSH = 1'b1
  } ctrl_state_t;

  // Each value freezes the requesting stage and every stage below it.
  localparam stall_t STALL_NONE = 6'b000000;
  localparam stall_t STALL_ID   = 6'b000111;
  localparam stall_t STALL_EX   = 6'b001111;
  localparam stall_t STALL_MEM  = 6'b011111;
  localparam stall_t STALL_ALL  = 6'b111111;

endpackage
`default_nettype wire

// File: rtl/stall_watchdog.sv
`default_nettype none
// stall_watchdog: counts consecutive requested-stall cycles and latches a sticky timeout flag.
module stall_watchdog
  import project_types::*;
#(
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic          clk,
  input  reset_status_t rst,
  input  logic          req_any,
  input  logic          clr,
  output logic          timeout
);

  localparam int            CW    = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STALL_TIMEOUT);

  logic [CW-1:0] run_q, run_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    run_d = '0;
    if (req_any && !clr) begin
      run_d = (run_q == '1) ? run_q : run_q + 1'b1;
    end
    timeout_d = timeout_q | (run_d >= LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      run_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      run_q     <= run_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// pipeline_ctrl: merges per-stage stall requests, sequences exceptions freeze -> flush,
// and tracks stall-cycle statistics plus a stuck-stall watchdog.
module pipeline_ctrl
  import project_types::*;
#(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  reset_status_t    rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             excp_valid,
  input  pc_t              excp_pc,
  output stall_t           stall,
  output logic             flush,
  output pc_t              new_pc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             stall_timeout
);

  ctrl_state_t      state_q, state_d;
  logic             flush_q, flush_d;
  pc_t              new_pc_q, new_pc_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             req_any;
  logic             wd_clr;

  always_comb begin
    state_d  = state_q;
    flush_d  = 1'b0;
    new_pc_d = new_pc_q;
    stall    = STALL_NONE;
    case (state_q)
      CTRL_RUN: begin
        if (excp_valid) begin
          // Freeze everything so the excepting instruction stays put for one cycle.
          state_d  = CTRL_FLUSH;
          flush_d  = 1'b1;
          new_pc_d = excp_pc;
          stall    = STALL_ALL;
        end else if (stallreq_mem) begin
          stall = STALL_MEM;
        end else if (stallreq_ex) begin
          stall = STALL_EX;
        end else if (stallreq_id) begin
          stall = STALL_ID;
        end
      end
      CTRL_FLUSH: begin
        state_d = CTRL_RUN;
      end
      default: begin
        state_d = CTRL_RUN;
      end
    endcase
    if (rst == RST_ENABLE) begin
      stall = STALL_NONE;
    end
    cyc_d = ((stall != STALL_NONE) && (cyc_q != '1)) ? cyc_q + 1'b1 : cyc_q;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q  <= CTRL_RUN;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
      cyc_q    <= cyc_d;
    end
  end

  assign req_any = (state_q == CTRL_RUN) && (stallreq_id || stallreq_ex || stallreq_mem);
  assign wd_clr  = (state_q == CTRL_FLUSH);

  stall_watchdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .req_any(req_any),
    .clr    (wd_clr),
    .timeout(stall_timeout)
  );

  assign flush        = flush_q;
  assign new_pc       = new_pc_q;
  assign stall_cycles = cyc_q;

endmodule
`default_nettype wire
